// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: sequences one whack-a-mole game as a fixed number of rounds.
// Each round picks a hole from a free-running LFSR, shows the mole for a
// difficulty-dependent time, judges the switch edges as hit or miss, and then
// blanks the field for a gap before the next round.
//
// Handshake: mole_valid qualifies mole_index. While mole_valid is high,
// mole_index names the lit hole (0..8). While it is low, mole_index is 4'hF.
// The video unit only observes these outputs and has no ready back-pressure.
module mole_round_ctrl #(
    parameter int TW         = 32,
    parameter int EASY_TICKS = 300000000,
    parameter int MED_TICKS  = 200000000,
    parameter int HARD_TICKS = 100000000,
    parameter int GAP_TICKS  = 50000000,
    parameter int ROUNDS     = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start_easy,
    input  logic       start_med,
    input  logic       start_hard,
    input  logic [8:0] sw,
    input  logic       Ack,
    output logic [3:0] mole_index,
    output logic       mole_valid,
    output logic [6:0] score,
    output logic [6:0] misses,
    output logic [6:0] round_cnt,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state,
    output logic [3:0] dbg_lfsr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PICK = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [TW-1:0] EASY_T   = TW'(EASY_TICKS);
    localparam logic [TW-1:0] MED_T    = TW'(MED_TICKS);
    localparam logic [TW-1:0] HARD_T   = TW'(HARD_TICKS);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
    localparam logic [6:0]    ROUNDS_C = 7'(ROUNDS);
    localparam logic [6:0]    CNT_MAX  = 7'd127;
    localparam logic [3:0]    NO_MOLE  = 4'hF;
    localparam logic [3:0]    LFSR_SEED = 4'b1011;

    // Registered state
    state_t        r_state;
    logic [3:0]    r_lfsr;
    logic [8:0]    r_sw_q;
    logic [3:0]    r_prev_idx;
    logic [3:0]    r_mole_index;
    logic          r_mole_valid;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] r_show_ticks;
    logic [6:0]    r_score;
    logic [6:0]    r_misses;
    logic [6:0]    r_round_cnt;

    // Combinational helpers
    logic [8:0]    w_edge;
    logic [8:0]    w_target;
    logic          w_hit;
    logic          w_wrong;
    logic          w_expire;
    logic          w_resolve;
    logic          w_any_start;
    logic          w_pick_ok;
    logic [TW-1:0] w_start_ticks;
    logic [TW-1:0] w_show_last;

    // Counters stop at the top of their 7-bit range instead of wrapping.
    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v == CNT_MAX) ? v : v + 7'd1;
    endfunction

    // Only rising switch edges count; a switch held from before never hits.
    assign w_edge   = sw & ~r_sw_q;
    // One-hot mask of the lit hole; all zero when no mole is shown.
    assign w_target = 9'd1 << r_mole_index;
    assign w_hit    = |(w_edge & w_target);
    assign w_wrong  = |(w_edge & ~w_target);

    assign w_show_last = r_show_ticks - {{(TW-1){1'b0}}, 1'b1};
    assign w_expire    = (r_timer == w_show_last);
    // A target edge, a wrong edge or expiry closes the round exactly once.
    assign w_resolve   = w_hit || w_wrong || w_expire;

    assign w_any_start = start_easy || start_med || start_hard;
    // Holes are 0..8 and a hole never repeats back-to-back.
    assign w_pick_ok   = (r_lfsr <= 4'd8) && (r_lfsr != r_prev_idx);

    // Difficulty select for the show time, easy wins over medium over hard.
    always_comb begin
        w_start_ticks = HARD_T;
        if (start_easy) begin
            w_start_ticks = EASY_T;
        end else if (start_med) begin
            w_start_ticks = MED_T;
        end
    end

    // LFSR (x^4+x^3+1) and switch history advance every cycle in every state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr <= LFSR_SEED;
            r_sw_q <= '0;
        end else begin
            r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
            r_sw_q <= sw;
        end
    end

    // Round sequencer with registered mole and score outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_prev_idx   <= NO_MOLE;
            r_mole_index <= NO_MOLE;
            r_mole_valid <= 1'b0;
            r_timer      <= '0;
            r_show_ticks <= '0;
            r_score      <= '0;
            r_misses     <= '0;
            r_round_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_start) begin
                        r_show_ticks <= w_start_ticks;
                        r_score      <= '0;
                        r_misses     <= '0;
                        r_round_cnt  <= '0;
                        r_prev_idx   <= NO_MOLE;
                        r_state      <= S_PICK;
                    end
                end

                S_PICK: begin
                    // Reject out-of-range or repeated LFSR values and retry
                    // next cycle; the LFSR period bounds this to 15 cycles.
                    if (w_pick_ok) begin
                        r_mole_index <= r_lfsr;
                        r_prev_idx   <= r_lfsr;
                        r_mole_valid <= 1'b1;
                        r_timer      <= '0;
                        r_state      <= S_SHOW;
                    end
                end

                S_SHOW: begin
                    r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
                    if (w_hit) begin
                        r_score <= sat_inc(r_score);
                    end else if (w_wrong || w_expire) begin
                        r_misses <= sat_inc(r_misses);
                    end
                    if (w_resolve) begin
                        r_round_cnt  <= sat_inc(r_round_cnt);
                        r_mole_index <= NO_MOLE;
                        r_mole_valid <= 1'b0;
                        r_timer      <= '0;
                        r_state      <= S_GAP;
                    end
                end

                S_GAP: begin
                    // round_cnt already includes the round that just ended.
                    if (r_timer == GAP_LAST) begin
                        r_timer <= '0;
                        if (r_round_cnt == ROUNDS_C) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_PICK;
                        end
                    end else begin
                        r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
                    end
                end

                S_DONE: begin
                    // Counters hold so the final result stays on display.
                    if (Ack) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mole_index = r_mole_index;
    assign mole_valid = r_mole_valid;
    assign score      = r_score;
    assign misses     = r_misses;
    assign round_cnt  = r_round_cnt;
    assign busy       = (r_state == S_PICK) || (r_state == S_SHOW) || (r_state == S_GAP);
    assign done       = (r_state == S_DONE);
    assign dbg_state  = r_state;
    assign dbg_lfsr   = r_lfsr;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl with short timings: EASY=8, MED=6, HARD=4,
// GAP=2, ROUNDS=3. Every finished round is popped from exp_q by a monitor.
module tb_mole_round_ctrl;

  localparam int W = 34;  // {chk_idx, idx[3:0], len[7:0], score, misses, rounds}
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // ---------------- clock / reset / DUT ----------------
  logic       Clk = 1'b0;
  logic       Reset;
  logic       start_easy, start_med, start_hard;
  logic [8:0] sw;
  logic       Ack;
  logic [3:0] mole_index;
  logic       mole_valid;
  logic [6:0] score, misses, round_cnt;
  logic       busy, done;
  logic [2:0] dbg_state;
  logic [3:0] dbg_lfsr;

  always #5 Clk = ~Clk;

  mole_round_ctrl #(
    .TW(32), .EASY_TICKS(8), .MED_TICKS(6), .HARD_TICKS(4),
    .GAP_TICKS(2), .ROUNDS(3)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .start_easy(start_easy), .start_med(start_med), .start_hard(start_hard),
    .sw(sw), .Ack(Ack),
    .mole_index(mole_index), .mole_valid(mole_valid),
    .score(score), .misses(misses), .round_cnt(round_cnt),
    .busy(busy), .done(done),
    .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0] lfsr_seq [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic ci, input logic [3:0] idx, input int len,
                                      input int sc, input int ms, input int rc);
    logic [7:0] l8;
    logic [6:0] s7, m7, r7;
    l8 = len[7:0];
    s7 = sc[6:0];
    m7 = ms[6:0];
    r7 = rc[6:0];
    return {ci, idx, l8, s7, m7, r7};
  endfunction

  function automatic logic [8:0] oh(input int i);
    logic [8:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: measures each shown mole and checks the round result when it ends.
  initial begin
    bit prev_v;
    int len;
    logic [3:0] idx;
    logic [W-1:0] e;
    prev_v = 1'b0;
    len = 0;
    idx = 4'h0;
    forever begin
      @(negedge Clk);
      if (mole_valid === 1'b1) begin
        if (!prev_v) begin
          len = 0;
          idx = mole_index;
        end
        len++;
      end else if (prev_v && Reset === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL round_unexpected: got round end with idx %0h, expected none", idx);
        end else begin
          e = exp_q.pop_front();
          if (e[33]) check("round_idx", 32'(idx), 32'(e[32:29]));
          check("round_len", 32'(len), 32'(e[28:21]));
          check("round_score", 32'(score), 32'(e[20:14]));
          check("round_misses", 32'(misses), 32'(e[13:7]));
          check("round_cnt", 32'(round_cnt), 32'(e[6:0]));
        end
      end
      prev_v = (mole_valid === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(output logic [3:0] idx);
    int k;
    k = 0;
    while (mole_valid !== 1'b1 && k < 200) begin
      @(negedge Clk);
      k++;
    end
    if (mole_valid !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_valid: got no mole in %0d cycles, expected one", k);
    end
    idx = mole_index;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done !== 1'b1 && k < 500) begin
      @(negedge Clk);
      k++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int sc, input int ms, input int rc);
    check({tag, "_mole_index"}, 32'(mole_index), 32'hF);
    check({tag, "_mole_valid"}, 32'(mole_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_score"}, 32'(score), 32'(sc));
    check({tag, "_misses"}, 32'(misses), 32'(ms));
    check({tag, "_round_cnt"}, 32'(round_cnt), 32'(rc));
  endtask

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] idx;
    lfsr_seq = '{4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2,
                 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5};
    Reset = 1'b1;
    start_easy = 1'b0; start_med = 1'b0; start_hard = 1'b0;
    sw = '0;
    Ack = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // Reset state and idle LFSR sequence.
    check_outputs("reset", 0, 0, 0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_lfsr", 32'(dbg_lfsr), 32'hB);
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      check("idle_lfsr", 32'(dbg_lfsr), 32'(lfsr_seq[i % 15]));
    end
    check_outputs("idle", 0, 0, 0);
    check("idle_done", 32'(done), 32'd0);

    // Hard game, no switches: holes 1, 5, 1, each shown 4 cycles, all misses.
    exp_q.push_back(mk(1'b1, 4'd1, 4, 0, 1, 1));
    exp_q.push_back(mk(1'b1, 4'd5, 4, 0, 2, 2));
    exp_q.push_back(mk(1'b1, 4'd1, 4, 0, 3, 3));
    start_hard = 1'b1;
    @(negedge Clk);
    start_hard = 1'b0;
    check("hard_busy", 32'(busy), 32'd1);
    wait_done();
    check_outputs("hard_end", 0, 3, 3);
    pulse_ack();
    check("hard_ack_done", 32'(done), 32'd0);
    check("hard_ack_misses", 32'(misses), 32'd3);

    // Easy game, target switch on the second SHOW cycle: three hits.
    start_easy = 1'b1;
    @(negedge Clk);
    start_easy = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      exp_q.push_back(mk(1'b0, 4'h0, 2, r, 0, r));
      wait_valid(idx);
      @(negedge Clk);
      sw = oh(int'(idx));
      @(negedge Clk);
      check("easy_score_after_edge", 32'(score), 32'(r));
      sw = '0;
    end
    wait_done();
    start_med = 1'b1;
    @(negedge Clk);
    start_med = 1'b0;
    repeat (3) @(negedge Clk);
    check("done_ignores_start", 32'(dbg_state), 32'(ST_DONE));
    check("done_score_held", 32'(score), 32'd3);
    pulse_ack();
    check("easy_ack_state", 32'(dbg_state), 32'(ST_IDLE));
    check_outputs("easy_ack", 3, 0, 3);

    // Medium game with every switch already held: no edges, all expire as misses.
    sw = 9'h1FF;
    start_med = 1'b1;
    for (int r = 1; r <= 3; r++) exp_q.push_back(mk(1'b0, 4'h0, 6, 0, r, r));
    @(negedge Clk);
    start_med = 1'b0;
    wait_done();
    sw = '0;
    check_outputs("held_end", 0, 3, 3);
    pulse_ack();

    // Easy and hard together: easy time. Hit+wrong, wrong only, hit at expiry.
    start_easy = 1'b1;
    start_hard = 1'b1;
    @(negedge Clk);
    start_easy = 1'b0;
    start_hard = 1'b0;
    exp_q.push_back(mk(1'b0, 4'h0, 2, 1, 0, 1));
    wait_valid(idx);
    @(negedge Clk);
    sw = oh(int'(idx)) | oh((int'(idx) + 1) % 9);
    @(negedge Clk);
    sw = '0;
    exp_q.push_back(mk(1'b0, 4'h0, 2, 1, 1, 2));
    wait_valid(idx);
    @(negedge Clk);
    sw = oh((int'(idx) + 1) % 9);
    @(negedge Clk);
    check("wrong_misses", 32'(misses), 32'd1);
    check("wrong_to_gap", 32'(dbg_state), 32'(ST_GAP));
    sw = '0;
    exp_q.push_back(mk(1'b0, 4'h0, 8, 2, 1, 3));
    wait_valid(idx);
    repeat (7) @(negedge Clk);
    sw = oh(int'(idx));
    @(negedge Clk);
    sw = '0;
    wait_done();
    check_outputs("mixed_end", 2, 1, 3);
    pulse_ack();

    // Reset in the middle of SHOW: everything back to reset values, no residual round.
    start_med = 1'b1;
    @(negedge Clk);
    start_med = 1'b0;
    wait_valid(idx);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_outputs("midreset", 0, 0, 0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_lfsr", 32'(dbg_lfsr), 32'hB);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    check("post_reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_reset_valid", 32'(mole_valid), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
